// File: rtl/truth_table_sweeper.sv
// ============================================================================
// Module      : truth_table_sweeper
// Description : Walks a 4-input function block through all 16 input vectors,
//               captures its truth table and compares it with an expected one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] exp_tt,
    input  logic        f_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail_idx
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0] c_idx_last    = 4'd15;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_idx;
    logic [7:0]  r_cnt;
    logic [15:0] r_exp;
    logic [15:0] r_tt;
    logic [4:0]  r_mcnt;
    logic [3:0]  r_ffi;
    logic        r_pass;
    logic        r_done;
    logic        w_active;
    logic        w_bad;
    logic [4:0]  w_mcnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_nxt = c_st_settle;
            c_st_settle: if (r_cnt == c_settle_last) w_state_nxt = c_st_sample;
            c_st_sample: w_state_nxt = (r_idx == c_idx_last) ? c_st_done : c_st_settle;
            c_st_done:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    assign w_bad      = (f_in != r_exp[r_idx]);
    assign w_mcnt_nxt = r_mcnt + {4'd0, w_bad};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= 4'd0;
            r_cnt  <= 8'd0;
            r_exp  <= 16'd0;
            r_tt   <= 16'd0;
            r_mcnt <= 5'd0;
            r_ffi  <= 4'd0;
            r_pass <= 1'b0;
            r_done <= 1'b0;
        end else begin
            // done is registered off the DONE state, so the pulse trails it by one cycle
            r_done <= (r_state == c_st_done);
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_exp  <= exp_tt;
                        r_tt   <= 16'd0;
                        r_mcnt <= 5'd0;
                        r_ffi  <= 4'd0;
                        r_pass <= 1'b0;
                        r_idx  <= 4'd0;
                        r_cnt  <= 8'd0;
                    end
                end
                c_st_settle: begin
                    r_cnt <= (r_cnt == c_settle_last) ? 8'd0 : r_cnt + 8'd1;
                end
                c_st_sample: begin
                    r_tt[r_idx] <= f_in;
                    r_mcnt      <= w_mcnt_nxt;
                    if (w_bad && (r_mcnt == 5'd0)) begin
                        r_ffi <= r_idx;
                    end
                    // pass must include this final vector's verdict, hence the next-count
                    if (r_idx == c_idx_last) begin
                        r_pass <= (w_mcnt_nxt == 5'd0);
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_active       = (r_state == c_st_settle) || (r_state == c_st_sample);
    assign {a, b, c, d}   = w_active ? r_idx : 4'd0;
    assign busy           = w_active;
    assign done           = r_done;
    assign tt             = r_tt;
    assign pass           = r_pass;
    assign mismatch_cnt   = r_mcnt;
    assign first_fail_idx = r_ffi;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Self-checking bench for truth_table_sweeper driving a
//               function block f = a&b | c&d.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] exp_tt;
    logic        f_in;
    logic        a, b, c, d;
    logic        busy, done, pass;
    logic [15:0] tt;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail_idx;
    logic        force0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign f_in = force0 ? 1'b0 : ((a & b) | (c & d));

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .exp_tt(exp_tt), .f_in(f_in),
        .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done), .tt(tt),
        .pass(pass), .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx)
    );

    typedef struct {
        logic [15:0] exp_in;
        logic        zero_f;
        logic [15:0] tt;
        logic        pass;
        logic [4:0]  cnt;
        logic [3:0]  ffi;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: the function block's truth table from its boolean definition
    function automatic logic [15:0] ref_tt(input logic zero_f);
        logic [15:0] t;
        t = 16'd0;
        for (int i = 0; i < 16; i++) begin
            logic va, vb, vc, vd;
            {va, vb, vc, vd} = 4'(i);
            t[i] = zero_f ? 1'b0 : ((va && vb) || (vc && vd));
        end
        return t;
    endfunction

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = 4'(i);
        end
        if (v == 16'd0) lowest_set = 4'd0;
    endfunction

    // One sweep: checks clearing, vector trace, latency and single-cycle done
    task automatic run_sweep(input logic [15:0] e, input logic zero_f);
        int trace_errs;
        int done_at;
        trace_errs = 0;
        done_at    = -1;
        @(negedge clk);
        exp_tt = e;
        force0 = zero_f;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        exp_tt = ~e;
        chk("cleared_tt", 32'(tt), 32'h0);
        chk("cleared_cnt", 32'(mismatch_cnt), 32'h0);
        chk("cleared_pass", 32'(pass), 32'h0);
        for (int n = 0; n < 200; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (n < 48) begin
                if (({a, b, c, d} !== 4'(n / 3)) || (busy !== 1'b1) || (done !== 1'b0))
                    trace_errs++;
            end else if (n == 48) begin
                if (({a, b, c, d} !== 4'd0) || (busy !== 1'b0) || (done !== 1'b0))
                    trace_errs++;
            end
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
        end
        chk("vector_trace", 32'(trace_errs), 32'h0);
        chk("done_latency", 32'(done_at), 32'd49);
    endtask

    task automatic check_result(input string tag, input logic [15:0] t, input logic p,
                                input logic [4:0] cnt, input logic [3:0] ffi);
        chk({tag, "_tt"}, 32'(tt), 32'(t));
        chk({tag, "_pass"}, 32'(pass), 32'(p));
        chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'(cnt));
        chk({tag, "_ffi"}, 32'(first_fail_idx), 32'(ffi));
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{16'hF888, 1'b0, 16'hF888, 1'b1, 5'd0,  4'd0};
        tbl[1] = '{16'hF889, 1'b0, 16'hF888, 1'b0, 5'd1,  4'd0};
        tbl[2] = '{16'hFFFF, 1'b1, 16'h0000, 1'b0, 5'd16, 4'd0};
        tbl[3] = '{16'h0000, 1'b0, 16'hF888, 1'b0, 5'd7,  4'd3};
        tbl[4] = '{16'h0777, 1'b0, 16'hF888, 1'b0, 5'd16, 4'd0};

        rst    = 1'b1;
        start  = 1'b0;
        exp_tt = 16'd0;
        force0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_abcd", 32'({a, b, c, d}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_tt", 32'(tt), 32'h0);
        chk("rst_pass", 32'(pass), 32'h0);
        chk("rst_cnt", 32'(mismatch_cnt), 32'h0);
        chk("rst_ffi", 32'(first_fail_idx), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table entries run back to back: each start lands right after the prior done
        for (int i = 0; i < 5; i++) begin
            run_sweep(tbl[i].exp_in, tbl[i].zero_f);
            check_result($sformatf("tbl%0d", i), tbl[i].tt, tbl[i].pass, tbl[i].cnt, tbl[i].ffi);
            @(posedge clk);
            #1;
            chk("done_one_cycle", 32'(done), 32'h0);
            check_result($sformatf("hold%0d", i), tbl[i].tt, tbl[i].pass, tbl[i].cnt, tbl[i].ffi);
        end
        force0 = 1'b0;

        // start held high: sweeps restart from IDLE every 50 cycles
        begin
            int pulses;
            int terr;
            pulses = 0;
            terr   = 0;
            @(negedge clk);
            exp_tt = 16'hF888;
            start  = 1'b1;
            @(posedge clk);
            #1;
            for (int n = 0; n < 149; n++) begin
                if (n > 0) begin
                    @(posedge clk);
                    #1;
                end
                if ((n % 50) < 48) begin
                    if (({a, b, c, d} !== 4'((n % 50) / 3)) || (busy !== 1'b1)) terr++;
                end
                if (done === 1'b1) pulses++;
            end
            start = 1'b0;
            chk("held_start_pulses", 32'(pulses), 32'd2);
            chk("held_start_trace", 32'(terr), 32'h0);
            repeat (4) @(posedge clk);
            #1;
            check_result("held", 16'hF888, 1'b1, 5'd0, 4'd0);
        end

        // Reset in the middle of vector 5
        begin
            int pulses;
            pulses = 0;
            @(negedge clk);
            exp_tt = 16'h0000;
            start  = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (16) @(posedge clk);
            #1;
            chk("pre_rst_abcd", 32'({a, b, c, d}), 32'd5);
            chk("pre_rst_cnt", 32'(mismatch_cnt), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("midrst_busy", 32'(busy), 32'h0);
            chk("midrst_abcd", 32'({a, b, c, d}), 32'h0);
            chk("midrst_tt", 32'(tt), 32'h0);
            chk("midrst_cnt", 32'(mismatch_cnt), 32'h0);
            chk("midrst_ffi", 32'(first_fail_idx), 32'h0);
            for (int n = 0; n < 60; n++) begin
                @(posedge clk);
                #1;
                if (done === 1'b1) pulses++;
            end
            chk("midrst_no_done", 32'(pulses), 32'h0);
        end

        // Random expected tables against the reference model
        for (int r = 0; r < 8; r++) begin
            logic [15:0] e;
            logic [15:0] t;
            e = 16'($urandom);
            t = ref_tt(1'b0);
            run_sweep(e, 1'b0);
            check_result($sformatf("rnd%0d", r), t, (t == e), 5'($countones(t ^ e)), lowest_set(t ^ e));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
